bounded_eventually_checker: RTL
===============================

# bounded_eventually_checker

Synthesizable bounded-liveness monitor that sits directly downstream of the signal under observation. After an arming pulse it watches `ev` for a fixed window of clock ticks, then reports pass, fail, or weak-pending at end of test. It gives hardware (and emulation) the same verdicts as a weak `eventually[MIN:MAX]` or strong `s_eventually[MIN:MAX]` property check.

## Interface
- `MIN_DLY`, default 1: first tick after arm at which `ev` counts; legal range 1..MAX_DLY.
- `MAX_DLY`, default 15: last tick of the window; legal range 1..255.
- `STRONG`, default 0: 1 means an unresolved window at `eot` is a failure; 0 means it is reported as pending only.
- `clk`, input, 1: single clock; every event is sampled on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: arms a check; sampled only in IDLE.
- `ev`, input, 1: the observed event.
- `eot`, input, 1: end-of-test; a level, first sampled high at an edge.
- `busy`, output, 1: high while ARMED.
- `pass`, output, 1: one-cycle pulse.
- `fail`, output, 1: one-cycle pulse.
- `pending`, output, 1: sticky; set when `eot` hits an open window and STRONG=0.
- `elapsed`, output, 8: current tick index k of the open window; 0 when not ARMED.
- `pass_cnt`, output, 16: saturating count of passes.
- `fail_cnt`, output, 16: saturating count of failures.

## Operation
- **States:** IDLE, ARMED, ENDED.
- **IDLE:**
  - `start`=1 → ARMED, with k=0.
  - `eot`=1 → ENDED. `eot` takes priority over `start`.
- **ARMED:** k increments by 1 every edge, so the first edge after the arm edge has k=1. At each edge, evaluate in this priority order:
  1. `ev`=1 and MIN_DLY ≤ k ≤ MAX_DLY → pulse `pass`, `pass_cnt`++, go to IDLE.
  2. k = MAX_DLY and `ev`=0 → pulse `fail`, `fail_cnt`++, go to IDLE.
  3. `eot`=1 → if STRONG, pulse `fail`, `fail_cnt`++; else set `pending`. In both cases go to ENDED.
- **Outside-window events:** `ev` high with k < MIN_DLY is ignored and is not a pass.
- **Single-thread check:** `start` while ARMED is ignored; no overlapping windows.
- **ENDED:** terminal. `start`, `ev` and `eot` are all ignored until reset.
- **Counters:** saturate at 16'hFFFF and never wrap.
- **Reset:** any edge with `rst_n`=0 forces IDLE and clears every output, the counters and k. This applies mid-window too; an open window is abandoned with no verdict.

## Timing
- **Arm latency:** `start` sampled at edge t0 gives `busy`=1 and `elapsed`=0 after t0. The window edges are t0+1 .. t0+MAX_DLY.
- **Verdict latency:** `pass`, `fail` and `pending` are registered. Each appears after the deciding edge and lasts one cycle (`pending` is sticky).
- **Re-arm:** the earliest new arm is the edge after the verdict, because IDLE samples `start` then.
- **Same-edge conflicts:** `ev` at k=MAX_DLY is a pass, never a fail. `eot` and an in-window `ev` at the same edge give pass, then IDLE; `eot` is acted on at the next edge.
- **Reset values:** `busy`=0, `pass`=0, `fail`=0, `pending`=0, `elapsed`=0, `pass_cnt`=0, `fail_cnt`=0.

## Structure
- **Package `ev_chk_pkg`:**
  - state enum `ev_state_t` {IDLE, ARMED, ENDED};
  - verdict enum `ev_verdict_t` {V_NONE, V_PASS, V_FAIL, V_PEND};
  - constant `EV_CNT_W` = 16.
- **Sub-module `ev_window_cnt`:** tick counter with clear/enable, plus compare outputs `in_win` and `at_max`. The top level holds the FSM, the verdict registers and the saturating counters.
- **Elaboration checks:** parameter legality (1 ≤ MIN_DLY ≤ MAX_DLY ≤ 255) is checked at elaboration.

## Test plan
All cases use MIN=1, MAX=15 and a 10 ns clock unless noted.
- **Pass at k=7:** `start` at t=15, `ev` high at the 7th following edge (t=85) → `pass` pulse after t=85, `pass_cnt`=1, `busy` drops.
- **Never-true fail:** `ev` held at 0 and `eot` at t=200 → `fail` after the 15th edge post-arm, then a re-arm fails again; at `eot`, STRONG=0 sets `pending`=1.
- **Weak vs strong at eot:** MAX=25, `ev`=0, `eot` at t=200 mid-window → STRONG=0 gives `pending`=1, `fail_cnt`=0; STRONG=1 gives a `fail` pulse, `fail_cnt`=1.
- **Window edges:** MIN=3, `ev` at k=2 only → fail at k=15. `ev` exactly at k=15 → pass, no fail. `eot` together with `ev` at k=4 → pass, then ENDED.
- **Arm/reset rules:** `start` re-pulsed at k=5 is ignored and `elapsed` keeps counting. `rst_n`=0 at k=9 → every output is 0 the next cycle and no verdict is issued. `start` in ENDED does nothing.
- **Counter saturation:** force `pass_cnt` to 16'hFFFE, then run 3 passes → value stays at 16'hFFFF.

Source files
------------

// File: rtl/ev_chk_pkg.sv
// Shared types and helpers for the bounded-eventually checker.
package ev_chk_pkg;

  localparam int unsigned EV_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ARMED, ENDED} ev_state_t;

  typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL, V_PEND} ev_verdict_t;

  function automatic logic [EV_CNT_W-1:0] sat_inc(input logic [EV_CNT_W-1:0] v);
    return (&v) ? v : v + EV_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ev_window_cnt.sv
// Window tick counter; compares report on the tick being decided at this edge.
module ev_window_cnt #(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] k,
  output logic       in_win,
  output logic       at_max
);

  logic [7:0] k_q;
  logic [8:0] tick;

  // The register holds the last completed tick; the edge now arriving is tick k_q+1.
  assign tick   = {1'b0, k_q} + 9'd1;
  assign in_win = (tick >= 9'(MIN_DLY)) && (tick <= 9'(MAX_DLY));
  assign at_max = (tick == 9'(MAX_DLY));
  assign k      = k_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      k_q <= '0;
    end else if (en) begin
      k_q <= tick[7:0];
    end
  end

endmodule

// File: rtl/bounded_eventually_checker.sv
// Bounded-liveness monitor: after start, ev must occur within ticks MIN_DLY..MAX_DLY.
module bounded_eventually_checker
  import ev_chk_pkg::*;
#(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 15,
  parameter bit          STRONG  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ev,
  input  logic                eot,
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic                pending,
  output logic [7:0]          elapsed,
  output logic [EV_CNT_W-1:0] pass_cnt,
  output logic [EV_CNT_W-1:0] fail_cnt
);

  if (!((MIN_DLY >= 1) && (MIN_DLY <= MAX_DLY) && (MAX_DLY <= 255))) begin : g_bad_params
    $error("bounded_eventually_checker: need 1 <= MIN_DLY <= MAX_DLY <= 255");
  end

  ev_state_t             state_q;
  ev_verdict_t           verdict;
  logic                  pass_q, fail_q, pending_q;
  logic [EV_CNT_W-1:0]   pass_cnt_q, fail_cnt_q;
  logic                  cnt_clr, cnt_en, in_win, at_max;

  ev_window_cnt #(
    .MIN_DLY (MIN_DLY),
    .MAX_DLY (MAX_DLY)
  ) u_win (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .k      (elapsed),
    .in_win (in_win),
    .at_max (at_max)
  );

  // Priority: in-window ev beats window expiry, which beats end-of-test.
  always_comb begin
    verdict = V_NONE;
    if (state_q == ARMED) begin
      if (ev && in_win) begin
        verdict = V_PASS;
      end else if (at_max) begin
        verdict = V_FAIL;
      end else if (eot) begin
        verdict = STRONG ? V_FAIL : V_PEND;
      end
    end
  end

  assign cnt_en  = (state_q == ARMED);
  assign cnt_clr = (state_q != ARMED) || (verdict != V_NONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pending_q  <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (eot) begin
            state_q <= ENDED;
          end else if (start) begin
            state_q <= ARMED;
          end
        end
        ARMED: begin
          case (verdict)
            V_PASS: begin
              pass_q     <= 1'b1;
              pass_cnt_q <= sat_inc(pass_cnt_q);
              state_q    <= IDLE;
            end
            V_FAIL: begin
              fail_q     <= 1'b1;
              fail_cnt_q <= sat_inc(fail_cnt_q);
              // Expiry returns to IDLE; a strong eot failure is terminal.
              state_q    <= at_max ? IDLE : ENDED;
            end
            V_PEND: begin
              pending_q <= 1'b1;
              state_q   <= ENDED;
            end
            default: ;
          endcase
        end
        ENDED: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == ARMED);
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign pending  = pending_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule
